// File: rtl/lvdc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lvdc_mem_pkg
//  Description : Shared definitions for the core-memory inhibit/write driver:
//                FSM state encoding, memory module select encoding, phase
//                length limits, the list of implemented buffer-register bit
//                indices, and a helper that turns a phase length into the
//                down-counter load value.
//  Revision    : 1.0 - initial release
// ============================================================================
package lvdc_mem_pkg;

    // FSM state encoding (explicit 2-bit width)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SETUP   = 2'd1;
    localparam state_t ST_DRIVE   = 2'd2;
    localparam state_t ST_RECOVER = 2'd3;

    // Target memory module select
    typedef enum logic [1:0] {
        MOD_A = 2'd0,
        MOD_B = 2'd1,
        MOD_C = 2'd2,
        MOD_D = 2'd3
    } mod_sel_e;

    // Legal range for WRITE_CYCLES / RECOVER_CYCLES (fits the 4-bit timer)
    localparam int unsigned CYCLES_MIN = 1;
    localparam int unsigned CYCLES_MAX = 15;

    localparam int unsigned NUM_MODULES = 4;
    localparam int unsigned NUM_IH_BITS = 10;

    // Buffer-register bit numbers that exist in the memory word, in the
    // order they are packed into the internal 10-bit data vector (LSB first).
    localparam int unsigned IH_BIT_INDEX [NUM_IH_BITS] = '{1, 2, 3, 4, 5, 7, 8, 10, 11, 13};

    // Load value for a phase lasting 'cycles' clocks: the timer reaches
    // terminal count after load_value further cycles. Out-of-range lengths
    // are clamped into the legal range.
    function automatic logic [3:0] phase_load(input int unsigned cycles);
        int unsigned c;
        c = cycles;
        if (c < CYCLES_MIN) c = CYCLES_MIN;
        if (c > CYCLES_MAX) c = CYCLES_MAX;
        return 4'(c - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : memory_phase_timer
//  Description : Loadable 4-bit down-counter with terminal-count flag. Loaded
//                on every phase entry; counts down to zero and holds there.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - load i_load_val this edge
//                i_load_val[3:0] - phase length minus one
//                o_tc            - counter is at terminal count (zero)
//                o_tc_next       - counter will be at terminal count after
//                                  the coming edge (lets outputs be registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_tc,
    output logic       o_tc_next
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            // Stops at zero: no wrap-around past terminal count
            r_count <= r_count - 4'd1;
        end
    end

    assign o_tc      = (r_count == 4'd0);
    assign o_tc_next = i_load ? (i_load_val == 4'd0) : (r_count <= 4'd1);

endmodule
`default_nettype wire

// File: rtl/memory_inhibit_driver_12.sv
`default_nettype none
// ============================================================================
//  Module      : memory_inhibit_driver_12
//  Description : Core-memory write-back driver. Latches ten buffer-register
//                bits and a target module on a write request, then sequences
//                SETUP (inhibit only), DRIVE (inhibit + write current) and
//                RECOVER (dead time) before returning to IDLE.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                WrReq                    - write-back request (IDLE only)
//                WrMod[1:0]               - target module 0..3 = Ma..Md
//                BRx1..BRx13 (10 bits)    - data bits to write
//                MxIHn (x=a..d, 10 bits)  - per-bit inhibit drive, high for 0 bits
//                MxWR                     - write current enable per module
//                Busy                     - not IDLE
//                WrDone                   - pulse in final RECOVER cycle
//                WrOvr                    - pulse per request seen while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_inhibit_driver_12
    import lvdc_mem_pkg::*;
#(
    parameter int unsigned WRITE_CYCLES   = 3,
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       WrReq,
    input  logic [1:0] WrMod,
    input  logic       BRx1,  BRx2,  BRx3,  BRx4,  BRx5,
    input  logic       BRx7,  BRx8,  BRx10, BRx11, BRx13,
    output logic       MaIH1, MaIH2, MaIH3, MaIH4, MaIH5, MaIH7, MaIH8, MaIH10, MaIH11, MaIH13,
    output logic       MbIH1, MbIH2, MbIH3, MbIH4, MbIH5, MbIH7, MbIH8, MbIH10, MbIH11, MbIH13,
    output logic       McIH1, McIH2, McIH3, McIH4, McIH5, McIH7, McIH8, McIH10, McIH11, McIH13,
    output logic       MdIH1, MdIH2, MdIH3, MdIH4, MdIH5, MdIH7, MdIH8, MdIH10, MdIH11, MdIH13,
    output logic       MaWR,  MbWR,  McWR,  MdWR,
    output logic       Busy,
    output logic       WrDone,
    output logic       WrOvr
);

    localparam logic [3:0] c_SETUP_LOAD   = phase_load(1);
    localparam logic [3:0] c_DRIVE_LOAD   = phase_load(WRITE_CYCLES);
    localparam logic [3:0] c_RECOVER_LOAD = phase_load(RECOVER_CYCLES);

    // Data bits packed in IH_BIT_INDEX order (bit 0 = BRx1 ... bit 9 = BRx13)
    logic [NUM_IH_BITS-1:0] w_brx;
    assign w_brx = {BRx13, BRx11, BRx10, BRx8, BRx7, BRx5, BRx4, BRx3, BRx2, BRx1};

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_load;
    logic [3:0]             w_load_val;
    logic                   w_tc;
    logic                   w_tc_next;
    logic                   w_accept;

    logic [NUM_IH_BITS-1:0] r_data;
    logic [NUM_IH_BITS-1:0] w_data_next;
    mod_sel_e               r_mod;
    mod_sel_e               w_mod_next;

    logic [NUM_MODULES-1:0][NUM_IH_BITS-1:0] r_ih;
    logic [NUM_MODULES-1:0][NUM_IH_BITS-1:0] w_ih_next;
    logic [NUM_MODULES-1:0]                  r_wr;
    logic [NUM_MODULES-1:0]                  w_wr_next;
    logic [NUM_MODULES-1:0]                  w_sel;
    logic                                    w_inhibit_phase;
    logic                                    w_write_phase;
    logic                                    r_busy;
    logic                                    r_done;
    logic                                    r_ovr;

    memory_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc),
        .o_tc_next  (w_tc_next)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (WrReq) begin
                    w_next_state = ST_SETUP;
                    w_load       = 1'b1;
                    w_load_val   = c_SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (w_tc) begin
                    w_next_state = ST_DRIVE;
                    w_load       = 1'b1;
                    w_load_val   = c_DRIVE_LOAD;
                end
            end
            ST_DRIVE: begin
                if (w_tc) begin
                    w_next_state = ST_RECOVER;
                    w_load       = 1'b1;
                    w_load_val   = c_RECOVER_LOAD;
                end
            end
            ST_RECOVER: begin
                if (w_tc) begin
                    w_next_state = ST_IDLE;
                    w_load       = 1'b1;
                    w_load_val   = 4'd0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept    = (r_state == ST_IDLE) && WrReq;
    // Acceptance-edge outputs must already reflect the incoming data
    assign w_data_next = w_accept ? w_brx : r_data;
    assign w_mod_next  = w_accept ? mod_sel_e'(WrMod) : r_mod;

    // ------------------------------------------------- inhibit/write decode
    // Outputs are registered, so decode is done on the next state.
    assign w_inhibit_phase = (w_next_state == ST_SETUP) || (w_next_state == ST_DRIVE);
    assign w_write_phase   = (w_next_state == ST_DRIVE);

    always_comb begin
        w_sel = '0;
        case (w_mod_next)
            MOD_A:   w_sel = 4'b0001;
            MOD_B:   w_sel = 4'b0010;
            MOD_C:   w_sel = 4'b0100;
            MOD_D:   w_sel = 4'b1000;
            default: w_sel = '0;
        endcase
    end

    always_comb begin
        w_ih_next = '0;
        w_wr_next = '0;
        for (int m = 0; m < NUM_MODULES; m++) begin
            // Inhibit opposes the write current for every bit to stay 0
            w_ih_next[m] = (w_sel[m] && w_inhibit_phase) ? ~w_data_next : '0;
            w_wr_next[m] = w_sel[m] && w_write_phase;
        end
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_mod   <= MOD_A;
            r_ih    <= '0;
            r_wr    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_data  <= w_data_next;
            r_mod   <= w_mod_next;
            r_ih    <= w_ih_next;
            r_wr    <= w_wr_next;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_RECOVER) && w_tc_next;
            r_ovr   <= (r_state != ST_IDLE) && WrReq;
        end
    end

    // ------------------------------------------------------------ outputs
    assign {MaIH13, MaIH11, MaIH10, MaIH8, MaIH7, MaIH5, MaIH4, MaIH3, MaIH2, MaIH1} = r_ih[0];
    assign {MbIH13, MbIH11, MbIH10, MbIH8, MbIH7, MbIH5, MbIH4, MbIH3, MbIH2, MbIH1} = r_ih[1];
    assign {McIH13, McIH11, McIH10, McIH8, McIH7, McIH5, McIH4, McIH3, McIH2, McIH1} = r_ih[2];
    assign {MdIH13, MdIH11, MdIH10, MdIH8, MdIH7, MdIH5, MdIH4, MdIH3, MdIH2, MdIH1} = r_ih[3];

    assign MaWR   = r_wr[0];
    assign MbWR   = r_wr[1];
    assign McWR   = r_wr[2];
    assign MdWR   = r_wr[3];
    assign Busy   = r_busy;
    assign WrDone = r_done;
    assign WrOvr  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_memory_inhibit_driver_12.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_inhibit_driver_12
//  Description : Self-checking bench. Two instances share one stimulus: the
//                default configuration and WRITE_CYCLES=1/RECOVER_CYCLES=15.
//                A behavioural model pushes expected outputs to a queue per
//                driven cycle; they are popped and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_inhibit_driver_12;

    typedef struct packed {
        logic [39:0] ih;    // [m*10 + b], m: 0=Ma..3=Md, b: BRx1,2,3,4,5,7,8,10,11,13
        logic [3:0]  wr;
        logic        busy;
        logic        done;
        logic        ovr;
    } obs_t;

    typedef struct {
        logic [1:0] mod;
        logic [9:0] brx;
        logic [9:0] exp_ih;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       WrReq;
    logic [1:0] WrMod;
    logic [9:0] brx;

    logic [39:0] d0_ih, d1_ih;
    logic [3:0]  d0_wr, d1_wr;
    logic        d0_busy, d0_done, d0_ovr, d1_busy, d1_done, d1_ovr;

    always #5 clk = ~clk;

    memory_inhibit_driver_12 u_dut0 (
        .clk(clk), .rst(rst), .WrReq(WrReq), .WrMod(WrMod),
        .BRx1(brx[0]), .BRx2(brx[1]), .BRx3(brx[2]), .BRx4(brx[3]), .BRx5(brx[4]),
        .BRx7(brx[5]), .BRx8(brx[6]), .BRx10(brx[7]), .BRx11(brx[8]), .BRx13(brx[9]),
        .MaIH1(d0_ih[0]),  .MaIH2(d0_ih[1]),  .MaIH3(d0_ih[2]),  .MaIH4(d0_ih[3]),  .MaIH5(d0_ih[4]),
        .MaIH7(d0_ih[5]),  .MaIH8(d0_ih[6]),  .MaIH10(d0_ih[7]), .MaIH11(d0_ih[8]), .MaIH13(d0_ih[9]),
        .MbIH1(d0_ih[10]), .MbIH2(d0_ih[11]), .MbIH3(d0_ih[12]), .MbIH4(d0_ih[13]), .MbIH5(d0_ih[14]),
        .MbIH7(d0_ih[15]), .MbIH8(d0_ih[16]), .MbIH10(d0_ih[17]), .MbIH11(d0_ih[18]), .MbIH13(d0_ih[19]),
        .McIH1(d0_ih[20]), .McIH2(d0_ih[21]), .McIH3(d0_ih[22]), .McIH4(d0_ih[23]), .McIH5(d0_ih[24]),
        .McIH7(d0_ih[25]), .McIH8(d0_ih[26]), .McIH10(d0_ih[27]), .McIH11(d0_ih[28]), .McIH13(d0_ih[29]),
        .MdIH1(d0_ih[30]), .MdIH2(d0_ih[31]), .MdIH3(d0_ih[32]), .MdIH4(d0_ih[33]), .MdIH5(d0_ih[34]),
        .MdIH7(d0_ih[35]), .MdIH8(d0_ih[36]), .MdIH10(d0_ih[37]), .MdIH11(d0_ih[38]), .MdIH13(d0_ih[39]),
        .MaWR(d0_wr[0]), .MbWR(d0_wr[1]), .McWR(d0_wr[2]), .MdWR(d0_wr[3]),
        .Busy(d0_busy), .WrDone(d0_done), .WrOvr(d0_ovr)
    );

    memory_inhibit_driver_12 #(.WRITE_CYCLES(1), .RECOVER_CYCLES(15)) u_dut1 (
        .clk(clk), .rst(rst), .WrReq(WrReq), .WrMod(WrMod),
        .BRx1(brx[0]), .BRx2(brx[1]), .BRx3(brx[2]), .BRx4(brx[3]), .BRx5(brx[4]),
        .BRx7(brx[5]), .BRx8(brx[6]), .BRx10(brx[7]), .BRx11(brx[8]), .BRx13(brx[9]),
        .MaIH1(d1_ih[0]),  .MaIH2(d1_ih[1]),  .MaIH3(d1_ih[2]),  .MaIH4(d1_ih[3]),  .MaIH5(d1_ih[4]),
        .MaIH7(d1_ih[5]),  .MaIH8(d1_ih[6]),  .MaIH10(d1_ih[7]), .MaIH11(d1_ih[8]), .MaIH13(d1_ih[9]),
        .MbIH1(d1_ih[10]), .MbIH2(d1_ih[11]), .MbIH3(d1_ih[12]), .MbIH4(d1_ih[13]), .MbIH5(d1_ih[14]),
        .MbIH7(d1_ih[15]), .MbIH8(d1_ih[16]), .MbIH10(d1_ih[17]), .MbIH11(d1_ih[18]), .MbIH13(d1_ih[19]),
        .McIH1(d1_ih[20]), .McIH2(d1_ih[21]), .McIH3(d1_ih[22]), .McIH4(d1_ih[23]), .McIH5(d1_ih[24]),
        .McIH7(d1_ih[25]), .McIH8(d1_ih[26]), .McIH10(d1_ih[27]), .McIH11(d1_ih[28]), .McIH13(d1_ih[29]),
        .MdIH1(d1_ih[30]), .MdIH2(d1_ih[31]), .MdIH3(d1_ih[32]), .MdIH4(d1_ih[33]), .MdIH5(d1_ih[34]),
        .MdIH7(d1_ih[35]), .MdIH8(d1_ih[36]), .MdIH10(d1_ih[37]), .MdIH11(d1_ih[38]), .MdIH13(d1_ih[39]),
        .MaWR(d1_wr[0]), .MbWR(d1_wr[1]), .McWR(d1_wr[2]), .MdWR(d1_wr[3]),
        .Busy(d1_busy), .WrDone(d1_done), .WrOvr(d1_ovr)
    );

    // ------------------------------------------------------------ model
    int         m_w   [2] = '{3, 1};
    int         m_r   [2] = '{1, 15};
    int         m_act [2] = '{0, 0};
    int         m_t   [2] = '{0, 0};
    logic       m_ovr [2] = '{1'b0, 1'b0};
    logic [9:0] m_data[2] = '{10'd0, 10'd0};
    logic [1:0] m_mod [2] = '{2'd0, 2'd0};

    obs_t sb0[$];
    obs_t sb1[$];

    int    checks   = 0;
    int    failures = 0;
    string cur_label = "init";

    int c_busy[2], c_wr[2], c_done[2], c_ovr[2], c_ih[2];

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_step(input int d);
        if (rst) begin
            m_act[d] = 0; m_t[d] = 0; m_ovr[d] = 1'b0; m_data[d] = '0; m_mod[d] = '0;
        end else if (m_act[d] == 0) begin
            m_ovr[d] = 1'b0;
            if (WrReq) begin
                m_act[d] = 1; m_t[d] = 0; m_data[d] = brx; m_mod[d] = WrMod;
            end
        end else begin
            m_ovr[d] = WrReq;
            if (m_t[d] == m_w[d] + m_r[d]) m_act[d] = 0;
            else m_t[d] = m_t[d] + 1;
        end
    endtask

    // Cycle t of an accepted write: 0 = SETUP, 1..W = DRIVE, W+1..W+R = RECOVER
    function automatic obs_t model_out(input int d);
        obs_t e;
        e = '0;
        e.ovr = m_ovr[d];
        if (m_act[d] != 0) begin
            e.busy = 1'b1;
            if (m_t[d] <= m_w[d]) e.ih[int'(m_mod[d])*10 +: 10] = ~m_data[d];
            if (m_t[d] >= 1 && m_t[d] <= m_w[d]) e.wr[m_mod[d]] = 1'b1;
            e.done = (m_t[d] == m_w[d] + m_r[d]);
        end
        return e;
    endfunction

    function automatic obs_t dut_obs(input int d);
        obs_t a;
        if (d == 0) a = '{ih: d0_ih, wr: d0_wr, busy: d0_busy, done: d0_done, ovr: d0_ovr};
        else        a = '{ih: d1_ih, wr: d1_wr, busy: d1_busy, done: d1_done, ovr: d1_ovr};
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            c_busy[d] = 0; c_wr[d] = 0; c_done[d] = 0; c_ovr[d] = 0; c_ih[d] = 0;
        end
    endtask

    // One clock: predict, push, clock, pop, compare
    task automatic step();
        obs_t e;
        obs_t a;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            e = model_out(d);
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            a = dut_obs(d);
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("%s dut%0d outputs", cur_label, d), 64'(a), 64'(e));
            c_busy[d] += int'(a.busy);
            c_wr[d]   += int'(|a.wr);
            c_done[d] += int'(a.done);
            c_ovr[d]  += int'(a.ovr);
            c_ih[d]   += int'(|a.ih);
        end
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{mod: 2'd2, brx: 10'b1111111111, exp_ih: 10'b0000000000};
        vt[1] = '{mod: 2'd0, brx: 10'b0111011110, exp_ih: 10'b1000100001};
        vt[2] = '{mod: 2'd1, brx: 10'b0000000000, exp_ih: 10'b1111111111};
        vt[3] = '{mod: 2'd3, brx: 10'b1010101010, exp_ih: 10'b0101010101};
        vt[4] = '{mod: 2'd1, brx: 10'b0000011111, exp_ih: 10'b1111100000};

        rst = 1'b1; WrReq = 1'b0; WrMod = 2'd0; brx = 10'd0;
        clear_counts();

        // Reset state
        cur_label = "reset";
        step();
        step();
        check("reset dut0 all outputs", 64'(dut_obs(0)), 64'd0);
        check("reset dut1 all outputs", 64'(dut_obs(1)), 64'd0);
        rst = 1'b0;
        step();

        // Single writes from the vector table
        for (int i = 0; i < 5; i++) begin
            cur_label = $sformatf("vec%0d", i);
            clear_counts();
            WrMod = vt[i].mod; brx = vt[i].brx; WrReq = 1'b1;
            step();
            check($sformatf("vec%0d dut0 selected ih", i),
                  64'(d0_ih[int'(vt[i].mod)*10 +: 10]), 64'(vt[i].exp_ih));
            WrReq = 1'b0;
            repeat (18) begin
                brx = 10'($urandom); WrMod = 2'($urandom);
                step();
            end
            check($sformatf("vec%0d dut0 busy cycles", i), 64'(c_busy[0]), 64'd5);
            check($sformatf("vec%0d dut0 wr cycles", i),   64'(c_wr[0]),   64'd3);
            check($sformatf("vec%0d dut0 done pulses", i), 64'(c_done[0]), 64'd1);
            check($sformatf("vec%0d dut0 ih cycles", i),   64'(c_ih[0]),
                  (vt[i].exp_ih != 10'd0) ? 64'd4 : 64'd0);
            check($sformatf("vec%0d dut1 busy cycles", i), 64'(c_busy[1]), 64'd17);
            check($sformatf("vec%0d dut1 wr cycles", i),   64'(c_wr[1]),   64'd1);
            check($sformatf("vec%0d dut1 done pulses", i), 64'(c_done[1]), 64'd1);
        end

        // Inputs toggled every cycle after acceptance
        cur_label = "toggle";
        clear_counts();
        WrMod = 2'd3; brx = 10'b1100110011; WrReq = 1'b1;
        step();
        WrReq = 1'b0;
        repeat (18) begin
            brx = ~brx; WrMod = WrMod + 2'd1;
            step();
        end
        check("toggle dut0 ih cycles", 64'(c_ih[0]), 64'd4);

        // Request held high for 12 sampled edges
        cur_label = "held";
        clear_counts();
        WrMod = 2'd1; brx = 10'b0110100101; WrReq = 1'b1;
        repeat (12) step();
        WrReq = 1'b0;
        repeat (20) step();
        check("held dut0 done pulses", 64'(c_done[0]), 64'd2);
        check("held dut0 ovr pulses",  64'(c_ovr[0]),  64'd10);
        check("held dut0 busy cycles", 64'(c_busy[0]), 64'd10);
        check("held dut1 done pulses", 64'(c_done[1]), 64'd1);
        check("held dut1 ovr pulses",  64'(c_ovr[1]),  64'd11);

        // Reset during the second DRIVE cycle
        cur_label = "abort";
        clear_counts();
        WrMod = 2'd1; brx = 10'h155; WrReq = 1'b1;
        step();
        WrReq = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort dut0 all outputs", 64'(dut_obs(0)), 64'd0);
        rst = 1'b0;
        repeat (6) step();
        check("abort dut0 no done", 64'(c_done[0]), 64'd0);
        check("abort dut1 no done", 64'(c_done[1]), 64'd0);

        cur_label = "after_abort";
        clear_counts();
        WrMod = 2'd2; brx = 10'h2AA; WrReq = 1'b1;
        step();
        WrReq = 1'b0;
        repeat (18) step();
        check("after_abort dut0 done", 64'(c_done[0]), 64'd1);
        check("after_abort dut0 busy", 64'(c_busy[0]), 64'd5);
        check("after_abort dut1 busy", 64'(c_busy[1]), 64'd17);

        // Request coincident with reset is ignored
        cur_label = "req_in_reset";
        clear_counts();
        rst = 1'b1; WrReq = 1'b1;
        step();
        rst = 1'b0; WrReq = 1'b0;
        repeat (3) step();
        check("req_in_reset dut0 busy", 64'(c_busy[0]), 64'd0);
        check("req_in_reset dut1 busy", 64'(c_busy[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
